serial_ripple_adder: RTL and testbench
======================================

// Module: serial_ripple_adder
// PURPOSE
//  Multi-cycle, digit-serial ripple-carry adder with valid/ready handshakes on input and output.
//  Adds two DATA_WIDTH-bit operands plus a carry-in, processing DIGIT_WIDTH bits per clock.
//  A single registered carry is propagated between digits.
//  Trades latency for area versus a fully combinational ripple adder.
//  Sits between stream producers and consumers in arithmetic datapaths.
// PARAMETERS
//  DATA_WIDTH   16  operand/sum width in bits
//  DIGIT_WIDTH   4  bits added per cycle; must divide DATA_WIDTH; elaboration error otherwise
//  (derived) N = DATA_WIDTH/DIGIT_WIDTH digit steps per operation
// PORTS
//  clk      in   1           clock, all logic on rising edge
//  rst      in   1           synchronous reset, active-high
//  din_a    in   DATA_WIDTH  operand a
//  din_b    in   DATA_WIDTH  operand b
//  din_ci   in   1           carry-in
//  din_vld  in   1           input valid
//  din_rd   out  1           input ready
//  dout_s   out  DATA_WIDTH  sum
//  dout_co  out  1           carry-out
//  dout_vld out  1           output valid
//  dout_rd  in   1           output ready
// BEHAVIOUR
//  - One clock (clk); reset rst is synchronous, active-high.
//  - Reset:
//    - state=IDLE; dout_vld=0; dout_s=0; dout_co=0; digit counter=0; carry reg=0.
//    - din_rd=0 while rst is high.
//  - FSM IDLE -> BUSY -> DONE -> IDLE. din_rd=1 only in IDLE; dout_vld=1 only in DONE.
//  - IDLE:
//    - On din_vld & din_rd, latch a, b and ci into operand shift registers and the carry reg.
//    - Clear the digit counter and go to BUSY.
//  - BUSY, step k = counter (0..N-1), lowest digit first:
//    - {c, d} = a[k*DW +: DW] + b[k*DW +: DW] + carry, computed at DW+1 bits.
//    - Store d into sum bits [k*DW +: DW]; carry <= c; counter++.
//    - At k == N-1, dout_co <= c and go to DONE.
//  - Sum register: bits of the running sum are unspecified while BUSY.
//    - dout_s/dout_co are stable and valid throughout DONE.
//  - DONE:
//    - Hold dout_s, dout_co and dout_vld until dout_vld & dout_rd.
//    - Then go to IDLE, with dout_vld=0 in the following cycle.
//  - Latency:
//    - Input accepted at edge t gives dout_vld=1 in the cycle after edge t+N.
//    - This is N+1 cycles with dout_rd held high.
//    - Peak throughput is one result per N+2 cycles.
//  - Back-to-back: a new input is never accepted in the DONE cycle; din_rd rises the cycle after the output handshake.
//  - Result is modulo 2^DATA_WIDTH; dout_co is the true carry out of bit DATA_WIDTH-1.
//  - N == 1 (DIGIT_WIDTH == DATA_WIDTH) is legal: one BUSY cycle.
//  - Inputs presented while not in IDLE are ignored; latched operands do not change during an operation.
//  - Reset mid-operation (BUSY or DONE):
//    - Abort; no dout_vld is emitted for that operand.
//    - Next cycle after rst deasserts: IDLE with din_rd=1.
//  - dout_rd is ignored outside DONE; din_vld may stay high without side effects.
// TESTING (DATA_WIDTH=16, DIGIT_WIDTH=4 unless noted)
//  1. a=0x00FF b=0x0001 ci=0, dout_rd=1 -> s=0x0100 co=0; dout_vld 5 cycles after accept, high 1 cycle.
//  2. a=0xFFFF b=0x0000 ci=1 -> s=0x0000 co=1; carry rippled through all 4 digits.
//  3. a=0x1234 b=0x4321 ci=0, dout_rd=0 for 7 cycles -> dout_vld held, s=0x5555 stable, din_rd=0 throughout.
//     Then dout_rd=1 -> handshake, din_rd=1 next cycle.
//  4. Reset asserted in the 2nd BUSY cycle -> no dout_vld ever for that op.
//     After rst: din_rd=1; a=0x0001 b=0x0001 -> s=0x0002.
//  5. DIGIT_WIDTH=16: a=0x8000 b=0x8000 ci=0 -> s=0x0000 co=1, dout_vld 2 cycles after accept.
//  6. 1000 random operands with random din_vld/dout_rd stalls -> every result equals (a+b+ci); order preserved.

Source files
------------

// File: rtl/serial_ripple_adder.sv
// Digit-serial ripple-carry adder: one DIGIT_WIDTH slice per clock with a registered carry.
// Latency N+1 cycles from accept to dout_vld; din_rd only when idle, result held until dout_rd.
module serial_ripple_adder #(
    parameter int DATA_WIDTH  = 16,
    parameter int DIGIT_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din_a,
    input  logic [DATA_WIDTH-1:0] din_b,
    input  logic                  din_ci,
    input  logic                  din_vld,
    output logic                  din_rd,
    output logic [DATA_WIDTH-1:0] dout_s,
    output logic                  dout_co,
    output logic                  dout_vld,
    input  logic                  dout_rd
);

    localparam int N  = DATA_WIDTH / DIGIT_WIDTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((DATA_WIDTH % DIGIT_WIDTH) != 0) begin : g_bad_digit
            $error("DIGIT_WIDTH must divide DATA_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [DATA_WIDTH-1:0] sum_q;
    logic                  carry_q;
    logic                  co_q;
    logic [CW-1:0]         cnt_q;
    logic [DIGIT_WIDTH:0]  digit_sum;
    logic                  last_step;
    logic                  accept;

    // One extra bit on the digit adder captures the carry into the next slice.
    always_comb begin
        digit_sum = {1'b0, a_q[cnt_q*DIGIT_WIDTH +: DIGIT_WIDTH]}
                  + {1'b0, b_q[cnt_q*DIGIT_WIDTH +: DIGIT_WIDTH]}
                  + {{DIGIT_WIDTH{1'b0}}, carry_q};
    end

    assign last_step = (cnt_q == CW'(N - 1));
    assign accept    = din_vld && din_rd;

    always_comb begin
        state_nxt = state_q;
        din_rd    = 1'b0;
        dout_vld  = 1'b0;
        case (state_q)
            IDLE: begin
                din_rd = !rst;
                if (din_vld && !rst) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                dout_vld = 1'b1;
                if (dout_rd) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            if (accept) begin
                a_q     <= din_a;
                b_q     <= din_b;
                carry_q <= din_ci;
                cnt_q   <= '0;
            end else if (state_q == BUSY) begin
                sum_q[cnt_q*DIGIT_WIDTH +: DIGIT_WIDTH] <= digit_sum[DIGIT_WIDTH-1:0];
                carry_q <= digit_sum[DIGIT_WIDTH];
                cnt_q   <= cnt_q + CW'(1);
                if (last_step) begin
                    co_q <= digit_sum[DIGIT_WIDTH];
                end
            end
        end
    end

    assign dout_s  = sum_q;
    assign dout_co = co_q;

endmodule

// File: tb/tb_serial_ripple_adder.sv
// Bench for serial_ripple_adder: queue-based reference model plus directed and random traffic.
`timescale 1ns/1ps
module tb_serial_ripple_adder;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din_a, din_b, dout_s;
    logic        din_ci, din_vld, din_rd, dout_co, dout_vld, dout_rd;
    logic [15:0] w_a, w_b, w_s;
    logic        w_ci, w_vld, w_din_rd, w_co, w_dout_vld, w_dout_rd;

    always #5 clk = ~clk;

    serial_ripple_adder #(.DATA_WIDTH(16), .DIGIT_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .din_a(din_a), .din_b(din_b), .din_ci(din_ci),
        .din_vld(din_vld), .din_rd(din_rd), .dout_s(dout_s), .dout_co(dout_co),
        .dout_vld(dout_vld), .dout_rd(dout_rd)
    );

    serial_ripple_adder #(.DATA_WIDTH(16), .DIGIT_WIDTH(16)) dut_w (
        .clk(clk), .rst(rst), .din_a(w_a), .din_b(w_b), .din_ci(w_ci),
        .din_vld(w_vld), .din_rd(w_din_rd), .dout_s(w_s), .dout_co(w_co),
        .dout_vld(w_dout_vld), .dout_rd(w_dout_rd)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected {co, sum} per accepted operand, in order,
    // plus the age of the operation in flight (clock edges since accept).
    logic [16:0] exp_q[$];
    bit          armed    = 1'b0;
    bit          inflight = 1'b0;
    int          age      = 0;
    int          n_done   = 0;

    always @(negedge clk) begin
        if (armed) begin
            check("din_rd", {31'b0, din_rd}, {31'b0, (!rst && !inflight)});
            check("dout_vld", {31'b0, dout_vld}, {31'b0, (inflight && age >= N)});
            if (inflight && age >= N && exp_q.size() > 0) begin
                check("dout_s", {16'b0, dout_s}, {16'b0, exp_q[0][15:0]});
                check("dout_co", {31'b0, dout_co}, {31'b0, exp_q[0][16]});
            end
        end
        if (rst) begin
            armed    = 1'b1;
            inflight = 1'b0;
            age      = 0;
            exp_q.delete();
        end else if (armed && inflight) begin
            if (age >= N && dout_rd) begin
                void'(exp_q.pop_front());
                inflight = 1'b0;
                n_done++;
            end else begin
                age++;
            end
        end else if (armed && din_vld) begin
            exp_q.push_back(17'(din_a) + 17'(din_b) + 17'(din_ci));
            inflight = 1'b1;
            age      = 0;
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic ci);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        din_a = a; din_b = b; din_ci = ci; din_vld = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (din_rd && !rst) ok = 1'b1;
        end
        @(posedge clk); #1;
        din_vld = 1'b0;
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_result(output int cyc);
        cyc = 1;
        while (cyc < 100) begin
            @(negedge clk);
            if (dout_vld) break;
            cyc++;
        end
    endtask

    initial begin
        int lat;
        int base;
        rst = 1'b1; din_vld = 1'b0; dout_rd = 1'b1; din_a = '0; din_b = '0; din_ci = 1'b0;
        w_vld = 1'b0; w_dout_rd = 1'b1; w_a = '0; w_b = '0; w_ci = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_dout_vld", {31'b0, dout_vld}, 32'd0);
        check("rst_dout_s", {16'b0, dout_s}, 32'd0);
        check("rst_dout_co", {31'b0, dout_co}, 32'd0);
        check("rst_din_rd", {31'b0, din_rd}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: carry across a digit boundary, five-cycle latency, single-cycle valid
        send(16'h00FF, 16'h0001, 1'b0);
        wait_result(lat);
        check("t1_latency", lat, 32'd5);
        check("t1_s", {16'b0, dout_s}, 32'h0100);
        check("t1_co", {31'b0, dout_co}, 32'd0);
        @(negedge clk);
        check("t1_vld_one_cycle", {31'b0, dout_vld}, 32'd0);

        // 2: carry-in ripples through every digit
        send(16'hFFFF, 16'h0000, 1'b1);
        wait_result(lat);
        check("t2_s", {16'b0, dout_s}, 32'h0000);
        check("t2_co", {31'b0, dout_co}, 32'd1);

        // 3: output stall holds result, blocks input
        @(posedge clk); #1;
        dout_rd = 1'b0;
        send(16'h1234, 16'h4321, 1'b0);
        wait_result(lat);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("t3_hold_vld", {31'b0, dout_vld}, 32'd1);
            check("t3_hold_s", {16'b0, dout_s}, 32'h5555);
            check("t3_hold_din_rd", {31'b0, din_rd}, 32'd0);
        end
        @(posedge clk); #1;
        dout_rd = 1'b1;
        @(negedge clk);
        check("t3_din_rd_in_done", {31'b0, din_rd}, 32'd0);
        @(negedge clk);
        check("t3_din_rd_after", {31'b0, din_rd}, 32'd1);
        check("t3_vld_after", {31'b0, dout_vld}, 32'd0);

        // 4: reset in the second busy cycle aborts the operation
        send(16'hAAAA, 16'h5555, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t4_din_rd", {31'b0, din_rd}, 32'd1);
        check("t4_s_cleared", {16'b0, dout_s}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t4_no_vld", {31'b0, dout_vld}, 32'd0);
        end
        send(16'h0001, 16'h0001, 1'b0);
        wait_result(lat);
        check("t4_s", {16'b0, dout_s}, 32'h0002);

        // 5: single-digit instance
        @(posedge clk); #1;
        w_a = 16'h8000; w_b = 16'h8000; w_ci = 1'b0; w_vld = 1'b1;
        @(negedge clk);
        check("t5_din_rd", {31'b0, w_din_rd}, 32'd1);
        @(posedge clk); #1;
        w_vld = 1'b0;
        lat = 1;
        while (lat < 100) begin
            @(negedge clk);
            if (w_dout_vld) break;
            lat++;
        end
        check("t5_latency", lat, 32'd2);
        check("t5_s", {16'b0, w_s}, 32'h0000);
        check("t5_co", {31'b0, w_co}, 32'd1);
        @(negedge clk);
        check("t5_vld_after", {31'b0, w_dout_vld}, 32'd0);
        check("t5_din_rd_after", {31'b0, w_din_rd}, 32'd1);

        // 6: random operands with random stalls on both sides
        base = n_done;
        for (int cyc = 0; cyc < 60000 && n_done < base + 1000; cyc++) begin
            @(posedge clk); #1;
            din_vld = ($urandom_range(0, 3) != 0);
            din_a   = 16'($urandom);
            din_b   = 16'($urandom);
            din_ci  = 1'($urandom);
            dout_rd = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        din_vld = 1'b0;
        dout_rd = 1'b1;
        repeat (10) @(posedge clk);
        check("t6_results_seen", {31'b0, (n_done >= base + 1000)}, 32'd1);
        check("t6_queue_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
